// File: rtl/aibio_hvmadc_seq.sv
// aibio_hvmadc_seq: round-robin scan sequencer and result averager around the
// HV monitor ADC, running in the adcclk domain. Each enabled channel is settled,
// converted 2^AVG_LOG2 times, averaged and published as a single result.
// Optional feature macro: AIBIO_HVMADC_SEQ_ALARM_EN builds the sticky per-channel
// threshold alarms. Without it, alarm_hi/alarm_lo are tied to zero and
// alarm_clr clears only timeout_err.
module aibio_hvmadc_seq #(
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 8,
    parameter int START_CYC  = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic       adcclk,
    input  logic       reset,
    input  logic       seq_en,
    input  logic [7:0] ch_mask,
    input  logic [9:0] thr_hi,
    input  logic [9:0] thr_lo,
    input  logic       alarm_clr,
    input  logic [9:0] adcout,
    input  logic       adcdone,
    output logic       adc_en,
    output logic [2:0] adc_anamux_sel,
    output logic       adc_start,
    output logic [9:0] result_data,
    output logic [2:0] result_ch,
    output logic       result_valid,
    output logic [7:0] alarm_hi,
    output logic [7:0] alarm_lo,
    output logic       timeout_err,
    output logic       busy
);

    localparam int NSAMP   = 1 << AVG_LOG2;
    localparam int ACC_W   = 10 + AVG_LOG2;
    localparam int SAMP_W  = AVG_LOG2 + 1;
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC) ?
                             ((TIMEOUT > START_CYC) ? TIMEOUT : START_CYC) :
                             ((SETTLE_CYC > START_CYC) ? SETTLE_CYC : START_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_START, S_WAIT, S_ACCUM, S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [9:0]          result_data_q, result_data_d;
    logic [2:0]          result_ch_q, result_ch_d;
    logic                result_valid_q;
    logic                timeout_err_q, timeout_err_d;
    logic                sync1_q, sync2_q, sync3_q;
    logic                done_evt;
    logic                pub;
    logic                tmo;
    logic [9:0]          avg;
    logic [ACC_W-1:0]    acc_sum;
    logic [SAMP_W-1:0]   samp_inc;

    // Lowest set bit of the mask; caller guarantees the mask is non-zero.
    function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) res = 3'(i);
        end
        return res;
    endfunction

    // Next set bit above cur, wrapping; a lone set bit yields cur again.
    function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // adcdone is asynchronous: two flops to resolve metastability, a third for edge detect.
    always_ff @(posedge adcclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= adcdone;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign done_evt = sync2_q & ~sync3_q;

    // State register plus sequencer datapath and published-result registers.
    always_ff @(posedge adcclk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= 3'd0;
            cnt_q          <= '0;
            acc_q          <= '0;
            samp_q         <= '0;
            result_data_q  <= 10'd0;
            result_ch_q    <= 3'd0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            samp_q         <= samp_d;
            result_data_q  <= result_data_d;
            result_ch_q    <= result_ch_d;
            result_valid_q <= pub;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Next-state and datapath update for the scan sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        samp_d   = samp_q;
        pub      = 1'b0;
        tmo      = 1'b0;
        acc_sum  = acc_q + ACC_W'(adcout);
        samp_inc = samp_q + SAMP_W'(1);
        avg      = acc_sum[ACC_W-1:AVG_LOG2];
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (seq_en && (ch_mask != 8'h00)) begin
                    ptr_d   = lowest_ch(ch_mask);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(START_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (done_evt) begin
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Give up on this channel: drop partial sum, move on.
                    tmo     = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    samp_d  = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACCUM: begin
                acc_d  = acc_sum;
                samp_d = samp_inc;
                if (samp_inc < SAMP_W'(NSAMP)) begin
                    // Same channel, mux already settled.
                    state_d = S_START;
                end else begin
                    pub     = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                acc_d  = '0;
                samp_d = '0;
                cnt_d  = '0;
                if (!seq_en || (ch_mask == 8'h00)) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d   = next_ch(ch_mask, ptr_q);
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        result_data_d = pub ? avg : result_data_q;
        result_ch_d   = pub ? ptr_q : result_ch_q;
        // A timeout landing together with a clear still leaves the flag set.
        timeout_err_d = tmo | (timeout_err_q & ~alarm_clr);
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        adc_en    = (state_q != S_IDLE);
        busy      = (state_q != S_IDLE);
        adc_start = (state_q == S_START);
    end

    assign adc_anamux_sel = ptr_q;
    assign result_data    = result_data_q;
    assign result_ch      = result_ch_q;
    assign result_valid   = result_valid_q;
    assign timeout_err    = timeout_err_q;

`ifdef AIBIO_HVMADC_SEQ_ALARM_EN
    logic [7:0] alarm_hi_q, alarm_hi_d;
    logic [7:0] alarm_lo_q, alarm_lo_d;
    logic [7:0] ch_onehot;

    // Threshold compare on the freshly published average; a set beats a clear.
    always_comb begin
        ch_onehot  = 8'b1 << ptr_q;
        alarm_hi_d = (alarm_clr ? 8'h00 : alarm_hi_q) |
                     ((pub && (avg > thr_hi)) ? ch_onehot : 8'h00);
        alarm_lo_d = (alarm_clr ? 8'h00 : alarm_lo_q) |
                     ((pub && (avg < thr_lo)) ? ch_onehot : 8'h00);
    end

    // Sticky alarm registers.
    always_ff @(posedge adcclk or posedge reset) begin
        if (reset) begin
            alarm_hi_q <= 8'h00;
            alarm_lo_q <= 8'h00;
        end else begin
            alarm_hi_q <= alarm_hi_d;
            alarm_lo_q <= alarm_lo_d;
        end
    end

    assign alarm_hi = alarm_hi_q;
    assign alarm_lo = alarm_lo_q;
`else
    logic unused_thr;
    assign unused_thr = ^{thr_hi, thr_lo};
    assign alarm_hi   = 8'h00;
    assign alarm_lo   = 8'h00;
`endif

endmodule

// File: tb/tb_aibio_hvmadc_seq.sv
// Self-checking bench for aibio_hvmadc_seq: a behavioural ADC model answers
// conversions per mux channel, expected averages go into a scoreboard queue as
// each scan is launched and are matched against result_valid strobes.
module tb_aibio_hvmadc_seq;

    localparam int ADC_DLY = 3;

`ifdef AIBIO_HVMADC_SEQ_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    logic       adcclk = 1'b0;
    logic       reset;
    logic       seq_en;
    logic [7:0] ch_mask;
    logic [9:0] thr_hi;
    logic [9:0] thr_lo;
    logic       alarm_clr;
    logic [9:0] adcout;
    logic       adcdone;
    logic       adc_en;
    logic [2:0] adc_anamux_sel;
    logic       adc_start;
    logic [9:0] result_data;
    logic [2:0] result_ch;
    logic       result_valid;
    logic [7:0] alarm_hi;
    logic [7:0] alarm_lo;
    logic       timeout_err;
    logic       busy;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   dead_ch = -1;
    bit   clr_on_final = 1'b0;

    aibio_hvmadc_seq #(
        .AVG_LOG2  (2),
        .SETTLE_CYC(8),
        .START_CYC (4),
        .TIMEOUT   (100)
    ) dut (
        .adcclk        (adcclk),
        .reset         (reset),
        .seq_en        (seq_en),
        .ch_mask       (ch_mask),
        .thr_hi        (thr_hi),
        .thr_lo        (thr_lo),
        .alarm_clr     (alarm_clr),
        .adcout        (adcout),
        .adcdone       (adcdone),
        .adc_en        (adc_en),
        .adc_anamux_sel(adc_anamux_sel),
        .adc_start     (adc_start),
        .result_data   (result_data),
        .result_ch     (result_ch),
        .result_valid  (result_valid),
        .alarm_hi      (alarm_hi),
        .alarm_lo      (alarm_lo),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 adcclk = ~adcclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Analog input seen by the ADC on each mux channel, k-th conversion.
    function automatic logic [9:0] adc_val(input int ch, input int k);
        case (ch)
            0:       return 10'(100 + 2 * k);
            1:       return 10'd300;
            2:       return 10'd512;
            3:       return 10'd700;
            4:       return 10'd20;
            5:       return 10'd250;
            6:       return 10'(400 + k);
            default: return 10'd1023;
        endcase
    endfunction

    function automatic logic [9:0] exp_avg(input int ch);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(adc_val(ch, k));
        return 10'(s / 4);
    endfunction

    task automatic expect_res(input int ch);
        exp_t e;
        e.ch  = 3'(ch);
        e.val = exp_avg(ch);
        sb.push_back(e);
    endtask

    // ADC model: conversion starts on adc_start, result appears ADC_DLY cycles after it ends.
    task automatic adc_model();
        logic start_prev;
        int   dly;
        int   post;
        int   mch;
        bit   fin;
        bit   drove_clr;
        int   idx[8];
        start_prev = 1'b0;
        dly = -1;
        post = -1;
        mch = 0;
        fin = 1'b0;
        drove_clr = 1'b0;
        for (int i = 0; i < 8; i++) idx[i] = 0;
        forever begin
            @(negedge adcclk);
            if (reset) begin
                for (int i = 0; i < 8; i++) idx[i] = 0;
                adcdone = 1'b0;
                dly = -1;
                post = -1;
                start_prev = 1'b0;
                if (drove_clr) alarm_clr = 1'b0;
                drove_clr = 1'b0;
                continue;
            end
            if (post >= 0) begin
                post++;
                if (post == 3) begin
                    if (fin) chk("valid_early", result_valid, 0);
                    if (fin && clr_on_final && mch == 3) begin
                        alarm_clr = 1'b1;
                        drove_clr = 1'b1;
                    end
                end else if (post == 4) begin
                    if (fin) chk("done_to_valid", result_valid, 1);
                    if (drove_clr) alarm_clr = 1'b0;
                    drove_clr = 1'b0;
                    post = -1;
                end
            end
            if (adc_start && !start_prev) begin
                adcdone = 1'b0;
                mch = int'(adc_anamux_sel);
            end
            if (!adc_start && start_prev) begin
                chk("mux_hold", adc_anamux_sel, mch);
                if (mch != dead_ch) dly = ADC_DLY;
            end
            start_prev = adc_start;
            if (dly > 0) begin
                dly--;
            end else if (dly == 0) begin
                adcout  = adc_val(mch, idx[mch]);
                adcdone = 1'b1;
                fin     = (idx[mch] == 3);
                idx[mch] = (idx[mch] + 1) % 4;
                dly  = -1;
                post = 0;
            end
        end
    endtask

    task automatic sb_monitor();
        exp_t e;
        forever begin
            @(negedge adcclk);
            if (!reset && result_valid) begin
                chk("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_ch", result_ch, e.ch);
                    chk("res_data", result_data, e.val);
                end
            end
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int got;
        int c;
        got = 0;
        c = 0;
        while (got < n && c < budget) begin
            @(negedge adcclk);
            c++;
            if (result_valid) got++;
        end
        if (got < n) chk("result_wait", got, n);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(negedge adcclk);
            c++;
        end
        if (busy) chk("idle_wait", busy, 0);
    endtask

    task automatic wait_start(input logic lvl, input int budget);
        int c;
        c = 0;
        while (adc_start !== lvl && c < budget) begin
            @(negedge adcclk);
            c++;
        end
        if (adc_start !== lvl) chk("start_wait", adc_start, lvl);
    endtask

    task automatic pulse_clr();
        @(negedge adcclk);
        alarm_clr = 1'b1;
        @(negedge adcclk);
        alarm_clr = 1'b0;
        @(negedge adcclk);
    endtask

    initial begin
        int c;
        reset     = 1'b1;
        seq_en    = 1'b0;
        ch_mask   = 8'h00;
        thr_hi    = 10'd512;
        thr_lo    = 10'd103;
        alarm_clr = 1'b0;
        adcout    = 10'd0;
        adcdone   = 1'b0;
        fork
            adc_model();
            sb_monitor();
        join_none

        // Reset state
        repeat (3) @(negedge adcclk);
        chk("rst0_ctrl", {adc_en, adc_start, busy, result_valid, timeout_err, adc_anamux_sel}, 0);
        chk("rst0_res", {result_ch, result_data}, 0);
        chk("rst0_alm", {alarm_hi, alarm_lo}, 0);
        reset = 1'b0;
        @(negedge adcclk);

        // Basic scan of ch0/ch2 with settle/start timing; thresholds equal averages
        ch_mask = 8'h05;
        expect_res(0);
        expect_res(2);
        expect_res(0);
        seq_en = 1'b1;
        @(negedge adcclk);
        chk("busy_on", busy, 1);
        chk("first_sel", adc_anamux_sel, 0);
        c = 0;
        while (!adc_start && c < 50) begin
            @(negedge adcclk);
            c++;
        end
        chk("settle_len", c, 8);
        c = 0;
        while (adc_start && c < 50) begin
            @(negedge adcclk);
            c++;
        end
        chk("start_len", c, 4);
        wait_results(3, 600);
        seq_en = 1'b0;
        wait_idle(50);
        chk("bnd_alm", {alarm_hi, alarm_lo}, 0);

        // Stop during WAIT: the in-flight channel still completes
        ch_mask = 8'h02;
        expect_res(1);
        seq_en = 1'b1;
        wait_start(1'b1, 50);
        wait_start(1'b0, 50);
        seq_en = 1'b0;
        wait_results(1, 300);
        @(negedge adcclk);
        chk("stop_busy", busy, 0);
        chk("stop_en", adc_en, 0);
        chk("stop_sel", adc_anamux_sel, 1);

        // Alarms
        thr_hi  = 10'd600;
        thr_lo  = 10'd50;
        ch_mask = 8'h18;
        expect_res(3);
        expect_res(4);
        seq_en = 1'b1;
        wait_results(2, 600);
        seq_en = 1'b0;
        wait_idle(50);
        chk("alm_hi", alarm_hi, ALM ? 8'h08 : 8'h00);
        chk("alm_lo", alarm_lo, ALM ? 8'h10 : 8'h00);
        chk("alm_tmo", timeout_err, 0);
        pulse_clr();
        chk("clr_hi", alarm_hi, 0);
        chk("clr_lo", alarm_lo, 0);

        // Clear colliding with a new ch3 publish
        ch_mask = 8'h08;
        clr_on_final = 1'b1;
        expect_res(3);
        seq_en = 1'b1;
        wait_results(1, 300);
        seq_en = 1'b0;
        wait_idle(50);
        clr_on_final = 1'b0;
        chk("collide_hi", alarm_hi, ALM ? 8'h08 : 8'h00);
        chk("collide_lo", alarm_lo, 0);

        // Timeout on ch5, scan continues to ch6
        dead_ch = 5;
        ch_mask = 8'h60;
        expect_res(6);
        seq_en = 1'b1;
        wait_start(1'b1, 50);
        chk("tmo_sel", adc_anamux_sel, 5);
        wait_start(1'b0, 50);
        c = 0;
        while (!timeout_err && c < 300) begin
            @(negedge adcclk);
            c++;
        end
        chk("tmo_cycle", c, 100);
        wait_results(1, 400);
        seq_en = 1'b0;
        wait_idle(50);
        dead_ch = -1;
        chk("tmo_sticky", timeout_err, 1);
        pulse_clr();
        chk("tmo_clr", timeout_err, 0);

        // Reset in START on ch3, restart from lowest channel
        ch_mask = 8'h0A;
        expect_res(1);
        seq_en = 1'b1;
        wait_results(1, 300);
        c = 0;
        while (!(adc_start && adc_anamux_sel == 3'd3) && c < 100) begin
            @(negedge adcclk);
            c++;
        end
        chk("rst_reach", {adc_start, adc_anamux_sel}, {1'b1, 3'd3});
        reset = 1'b1;
        #1;
        chk("rst_ctrl", {adc_en, adc_start, busy, result_valid, timeout_err, adc_anamux_sel}, 0);
        chk("rst_res", {result_ch, result_data}, 0);
        chk("rst_alm", {alarm_hi, alarm_lo}, 0);
        @(negedge adcclk);
        @(negedge adcclk);
        reset = 1'b0;
        expect_res(1);
        @(negedge adcclk);
        chk("restart_busy", busy, 1);
        chk("restart_sel", adc_anamux_sel, 1);
        wait_results(1, 300);
        seq_en = 1'b0;
        wait_idle(50);

        // Degenerate masks
        ch_mask = 8'h00;
        seq_en = 1'b1;
        repeat (5) @(negedge adcclk);
        chk("mask0_busy", busy, 0);
        chk("mask0_en", adc_en, 0);
        ch_mask = 8'h80;
        expect_res(7);
        expect_res(7);
        wait_results(1, 300);
        c = 0;
        while (!adc_start && c < 50) begin
            @(negedge adcclk);
            c++;
        end
        chk("resettle", c, 9);
        chk("ch7_sel", adc_anamux_sel, 7);
        wait_results(1, 300);
        seq_en = 1'b0;
        wait_idle(50);
        chk("ch7_hi", alarm_hi, ALM ? 8'h80 : 8'h00);
        chk("ch7_lo", alarm_lo, 0);

        repeat (3) @(negedge adcclk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
